// File: rtl/ras_pkg.sv
// Shared definitions for the return-address-stack controller and the stack itself.
package ras_pkg;

   typedef enum logic [1:0] {INIT, RUN, FLUSH} state_e;

   localparam int RAS_MAX_BRANCHES = 128;
   localparam int RAS_CLOSE_GAP    = 2;

   // Width needed to hold a count from 0 to n inclusive.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ras_close_sched.sv
// Close scheduler: counts correct resolutions awaiting a close_valid pulse and
// spaces the pulses with a reload-on-issue gap timer.
module ras_close_sched import ras_pkg::*; #(
   parameter int  MAX_BRANCHES = RAS_MAX_BRANCHES,
   parameter int  CLOSE_GAP    = RAS_CLOSE_GAP,
   localparam int CW           = cnt_w(MAX_BRANCHES),
   localparam int GW           = cnt_w(CLOSE_GAP)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run_i,
   input  logic          flush_i,
   input  logic          res_ok_i,
   output logic          close_issue_next_o,
   output logic [CW-1:0] pending_o
);

   logic [CW-1:0] pending_q, pending_d;
   logic [GW-1:0] gap_q, gap_d;

   // A resolution arriving this cycle may be closed immediately.
   always_comb begin
      close_issue_next_o = run_i && !flush_i && (gap_q == '0) &&
                           ((pending_q != '0) || res_ok_i);
      pending_d = pending_q;
      gap_d     = gap_q;
      if (!run_i || flush_i) begin
         pending_d = '0;
         gap_d     = '0;
      end else begin
         if (gap_q != '0)
            gap_d = gap_q - GW'(1);
         if (close_issue_next_o)
            gap_d = GW'(CLOSE_GAP);
         if (res_ok_i && !close_issue_next_o)
            pending_d = pending_q + CW'(1);
         else if (!res_ok_i && close_issue_next_o)
            pending_d = pending_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_q <= '0;
         gap_q     <= '0;
      end else begin
         pending_q <= pending_d;
         gap_q     <= gap_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/ras_ctrl.sv
// Drives the return address stack from fetch and branch resolution.
// Optional RAS_CTRL_STATS_EN adds saturating flush / full-stall counters.
module ras_ctrl import ras_pkg::*; #(
   parameter int  WIDTH        = 32,
   parameter int  MAX_BRANCHES = RAS_MAX_BRANCHES,
   parameter int  CLOSE_GAP    = RAS_CLOSE_GAP,
   localparam int CW           = cnt_w(MAX_BRANCHES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fe_call,
   input  logic             fe_ret,
   input  logic             fe_br,
   input  logic [WIDTH-1:0] fe_ret_addr,
   output logic             fe_ready,
   input  logic             res_valid,
   input  logic             res_mispredict,
   output logic             ras_push,
   output logic             ras_pop,
   output logic             ras_branch,
   output logic             ras_close_valid,
   output logic             ras_close_invalid,
   output logic [WIDTH-1:0] ras_din,
   input  logic [WIDTH-1:0] ras_dout,
   input  logic             ras_empty,
   output logic             ret_target_valid,
   output logic             ret_target_hit,
   output logic [WIDTH-1:0] ret_target,
   output logic [CW-1:0]    outstanding,
   output logic             err
`ifdef RAS_CTRL_STATS_EN
  ,output logic [31:0]      stat_flush,
   output logic [31:0]      stat_full_stall
`endif
);

   state_e           state_q, state_d;
   logic [CW-1:0]    outst_q, outst_d, pending;
   logic             push_q, pop_q, br_q, cv_q, cinv_q, rv_q, hit_q, err_q;
   logic [WIDTH-1:0] din_q;
   logic             run, matched, mis_now, res_ok, full, close_issue_next;
   logic             acc_call, acc_ret, acc_br;

   ras_close_sched #(.MAX_BRANCHES(MAX_BRANCHES), .CLOSE_GAP(CLOSE_GAP)) u_sched (
      .clk               (clk),
      .reset             (reset),
      .run_i             (run),
      .flush_i           (mis_now),
      .res_ok_i          (res_ok),
      .close_issue_next_o(close_issue_next),
      .pending_o         (pending)
   );

   // A resolution only matches a branch that is open and not yet resolved.
   always_comb begin
      run      = (state_q == RUN);
      matched  = (pending != outst_q);
      mis_now  = run && res_valid && res_mispredict && matched;
      res_ok   = run && res_valid && !res_mispredict && matched;
      full     = (outst_q == CW'(MAX_BRANCHES));
      fe_ready = reset && run && !mis_now && !close_issue_next && !(fe_br && full);
      acc_call = fe_ready && fe_call;
      acc_ret  = fe_ready && !fe_call && fe_ret;
      acc_br   = fe_ready && !fe_call && !fe_ret && fe_br;

      state_d = state_q;
      case (state_q)
         INIT:    state_d = RUN;
         RUN:     state_d = mis_now ? FLUSH : RUN;
         FLUSH:   state_d = RUN;
         default: state_d = INIT;
      endcase

      outst_d = outst_q;
      if (!run || mis_now)
         outst_d = '0;
      else if (acc_br)
         outst_d = outst_q + CW'(1);
      else if (close_issue_next)
         outst_d = outst_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= INIT;
         outst_q <= '0;
         push_q  <= 1'b0;
         pop_q   <= 1'b0;
         br_q    <= 1'b0;
         cv_q    <= 1'b0;
         cinv_q  <= 1'b0;
         din_q   <= '0;
         rv_q    <= 1'b0;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         outst_q <= outst_d;
         push_q  <= acc_call;
         pop_q   <= acc_ret;
         br_q    <= acc_br;
         cv_q    <= close_issue_next;
         cinv_q  <= (state_q == INIT) || mis_now;
         if (acc_call)
            din_q <= fe_ret_addr;
         rv_q    <= pop_q;
         hit_q   <= pop_q && !ras_empty;
         err_q   <= err_q || (run && res_valid && !matched);
      end
   end

   assign ras_push          = push_q;
   assign ras_pop           = pop_q;
   assign ras_branch        = br_q;
   assign ras_close_valid   = cv_q;
   assign ras_close_invalid = cinv_q;
   assign ras_din           = din_q;
   assign ret_target_valid  = rv_q;
   assign ret_target_hit    = hit_q;
   assign ret_target        = rv_q ? ras_dout : '0;
   assign outstanding       = outst_q;
   assign err               = err_q;

`ifdef RAS_CTRL_STATS_EN
   logic [31:0] sflush_q, sstall_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         sflush_q <= '0;
         sstall_q <= '0;
      end else begin
         if (mis_now && (sflush_q != '1))
            sflush_q <= sflush_q + 32'd1;
         if (run && fe_br && full && (sstall_q != '1))
            sstall_q <= sstall_q + 32'd1;
      end
   end

   assign stat_flush      = sflush_q;
   assign stat_full_stall = sstall_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a timestamp-based reference model and a stack stub.
module tb_ras_ctrl;
   localparam int W = 32, MB = 4, GAP = 2;

   logic clk = 1'b0, reset = 1'b0;
   logic fe_call = 0, fe_ret = 0, fe_br = 0, res_valid = 0, res_mispredict = 0;
   logic [W-1:0] fe_ret_addr = '0;
   logic fe_ready, ras_push, ras_pop, ras_branch, ras_close_valid, ras_close_invalid;
   logic [W-1:0] ras_din, ret_target;
   logic [W-1:0] dout_r = '0;
   logic ras_empty, ret_target_valid, ret_target_hit, err;
   logic [2:0] outstanding;

   int n_tests = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ras_ctrl #(.WIDTH(W), .MAX_BRANCHES(MB), .CLOSE_GAP(GAP)) dut (
      .clk(clk), .reset(reset), .fe_call(fe_call), .fe_ret(fe_ret), .fe_br(fe_br),
      .fe_ret_addr(fe_ret_addr), .fe_ready(fe_ready), .res_valid(res_valid),
      .res_mispredict(res_mispredict), .ras_push(ras_push), .ras_pop(ras_pop),
      .ras_branch(ras_branch), .ras_close_valid(ras_close_valid),
      .ras_close_invalid(ras_close_invalid), .ras_din(ras_din), .ras_dout(dout_r),
      .ras_empty(ras_empty), .ret_target_valid(ret_target_valid),
      .ret_target_hit(ret_target_hit), .ret_target(ret_target),
      .outstanding(outstanding), .err(err));

   // Stack stub: registered read data, combinational empty flag.
   logic [W-1:0] stk[$];
   int stk_n = 0;
   assign ras_empty = (stk_n == 0);
   always @(posedge clk) begin
      if (!reset) begin
         stk.delete();
         stk_n  <= 0;
         dout_r <= '0;
      end else if (ras_push) begin
         stk.push_back(ras_din);
         stk_n <= stk_n + 1;
      end else if (ras_pop && stk.size() > 0) begin
         dout_r <= stk.pop_back();
         stk_n  <= stk_n - 1;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: events are scheduled by cycle stamps rather than state.
   typedef struct {int cyc; bit hit; logic [W-1:0] tgt;} ret_t;
   ret_t m_ret[$];
   logic [W-1:0] m_stk[$];
   int m_out = 0, m_pend = 0, m_next_ok = 0, m_run_from = 0, m_cinv_at = -1;
   bit m_err = 0, armed = 0, e_push = 0, e_pop = 0, e_br = 0, e_cv = 0;
   logic [W-1:0] e_din = '0;

   always @(negedge clk) begin
      int t;
      bit run, match, mis, rok, iss, rdy, exp_rv;
      ret_t r;
      t      = cyc;
      run    = reset && (t >= m_run_from);
      match  = (m_pend != m_out);
      mis    = run && res_valid && res_mispredict && match;
      rok    = run && res_valid && !res_mispredict && match;
      iss    = run && !mis && (m_pend > 0 || rok) && (t >= m_next_ok);
      rdy    = run && !mis && !iss && !(fe_br && m_out == MB);
      exp_rv = (m_ret.size() > 0) && (m_ret[0].cyc == t);
      if (armed) begin
         chk("fe_ready", 32'(fe_ready), 32'(rdy));
         chk("ras_push", 32'(ras_push), 32'(e_push));
         chk("ras_pop", 32'(ras_pop), 32'(e_pop));
         chk("ras_branch", 32'(ras_branch), 32'(e_br));
         chk("close_valid", 32'(ras_close_valid), 32'(e_cv));
         chk("close_invalid", 32'(ras_close_invalid), 32'(t == m_cinv_at));
         chk("outstanding", 32'(outstanding), 32'(m_out));
         chk("err", 32'(err), 32'(m_err));
         chk("ret_valid", 32'(ret_target_valid), 32'(exp_rv));
         chk("ret_hit", 32'(ret_target_hit), exp_rv ? 32'(m_ret[0].hit) : 32'd0);
         if (e_push) chk("ras_din", ras_din, e_din);
         if (exp_rv && m_ret[0].hit) chk("ret_target", ret_target, m_ret[0].tgt);
      end
      if (exp_rv) void'(m_ret.pop_front());
      if (!reset) begin
         armed = 1; m_ret.delete(); m_stk.delete();
         m_out = 0; m_pend = 0; m_next_ok = 0; m_err = 0;
         m_run_from = t + 2; m_cinv_at = t + 2;
         e_push = 0; e_pop = 0; e_br = 0; e_cv = 0;
      end else begin
         e_push = rdy && fe_call;
         e_pop  = rdy && !fe_call && fe_ret;
         e_br   = rdy && !fe_call && !fe_ret && fe_br;
         e_cv   = iss;
         if (e_push) begin e_din = fe_ret_addr; m_stk.push_back(fe_ret_addr); end
         if (e_pop) begin
            r.cyc = t + 2;
            r.hit = (m_stk.size() > 0);
            r.tgt = r.hit ? m_stk.pop_back() : '0;
            m_ret.push_back(r);
         end
         if (run && res_valid && !match) m_err = 1;
         if (mis) begin
            m_out = 0; m_pend = 0; m_next_ok = 0;
            m_run_from = t + 2; m_cinv_at = t + 1;
         end else begin
            if (rok && !iss) m_pend++;
            if (iss && !rok) m_pend--;
            if (iss) begin m_out--; m_next_ok = t + GAP + 1; end
            if (e_br) m_out++;
         end
      end
   end

   task automatic tick(input logic c, input logic r, input logic b, input logic [31:0] a,
                       input logic rv, input logic rm);
      @(posedge clk); #1;
      fe_call = c; fe_ret = r; fe_br = b; fe_ret_addr = a; res_valid = rv; res_mispredict = rm;
      @(negedge clk);
   endtask

   task automatic idle();
      tick(0, 0, 0, '0, 0, 0);
   endtask

   task automatic rst_tick(input logic rs);
      @(posedge clk); #1;
      reset = rs; fe_call = 0; fe_ret = 0; fe_br = 0; res_valid = 0; res_mispredict = 0;
      @(negedge clk);
   endtask

   task automatic op_acc(input logic c, input logic r, input logic b, input logic [31:0] a);
      int k;
      k = 0;
      tick(c, r, b, a, 0, 0);
      while (!fe_ready && k < 20) begin tick(c, r, b, a, 0, 0); k++; end
      chk("handshake", 32'(fe_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) rst_tick(0);
      rst_tick(1);  // INIT cycle
      chk("init_ready", 32'(fe_ready), 32'd0);
      chk("init_cinv_early", 32'(ras_close_invalid), 32'd0);
      chk("rst_outst", 32'(outstanding), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      idle();
      chk("init_cinv", 32'(ras_close_invalid), 32'd1);
      chk("init_ready2", 32'(fe_ready), 32'd1);
      idle();
      chk("init_cinv_once", 32'(ras_close_invalid), 32'd0);

      // calls and returns
      op_acc(1, 0, 0, 32'h1000);
      op_acc(1, 0, 0, 32'h2000);
      chk("push_din", ras_din, 32'h1000);
      op_acc(0, 1, 0, '0);
      op_acc(0, 1, 0, '0);
      op_acc(0, 1, 0, '0);
      chk("ret1_valid", 32'(ret_target_valid), 32'd1);
      chk("ret1_tgt", ret_target, 32'h2000);
      chk("ret1_hit", 32'(ret_target_hit), 32'd1);
      idle();
      chk("ret2_tgt", ret_target, 32'h1000);
      chk("ret2_hit", 32'(ret_target_hit), 32'd1);
      idle();
      chk("ret3_valid", 32'(ret_target_valid), 32'd1);
      chk("ret3_hit", 32'(ret_target_hit), 32'd0);
      idle();

      // three branches, three correct resolutions back to back
      repeat (3) op_acc(0, 0, 1, '0);
      idle();
      chk("outst3", 32'(outstanding), 32'd3);
      tick(0, 0, 1, '0, 1, 0);
      chk("stall_c1", 32'(fe_ready), 32'd0);
      tick(0, 0, 0, '0, 1, 0);
      chk("close1", 32'(ras_close_valid), 32'd1);
      chk("outst2", 32'(outstanding), 32'd2);
      tick(0, 0, 0, '0, 1, 0);
      chk("gap_quiet", 32'(ras_close_valid), 32'd0);
      tick(0, 0, 1, '0, 0, 0);
      chk("stall_c2", 32'(fe_ready), 32'd0);
      idle();
      chk("close2", 32'(ras_close_valid), 32'd1);
      chk("outst1", 32'(outstanding), 32'd1);
      idle();
      tick(0, 0, 1, '0, 0, 0);
      chk("stall_c3", 32'(fe_ready), 32'd0);
      idle();
      chk("close3", 32'(ras_close_valid), 32'd1);
      chk("outst0", 32'(outstanding), 32'd0);
      idle();

      // full checkpoint capacity
      repeat (4) op_acc(0, 0, 1, '0);
      tick(0, 0, 1, '0, 0, 0);
      chk("full_stall", 32'(fe_ready), 32'd0);
      chk("outst_full", 32'(outstanding), 32'd4);
      tick(0, 0, 1, '0, 1, 0);
      chk("full_stall2", 32'(fe_ready), 32'd0);
      tick(0, 0, 1, '0, 0, 0);
      chk("full_release", 32'(fe_ready), 32'd1);
      chk("full_close", 32'(ras_close_valid), 32'd1);
      idle();
      chk("outst_refill", 32'(outstanding), 32'd4);
      tick(1, 0, 0, 32'hdead, 1, 1);  // mispredict drops the call
      chk("mis_ready", 32'(fe_ready), 32'd0);
      idle();
      chk("flush_cinv", 32'(ras_close_invalid), 32'd1);
      chk("flush_ready", 32'(fe_ready), 32'd0);
      chk("flush_outst", 32'(outstanding), 32'd0);
      chk("flush_drop", 32'(ras_push), 32'd0);
      idle();
      chk("flush_back", 32'(fe_ready), 32'd1);

      // 2 branches, 1 correct, then mispredict
      repeat (2) op_acc(0, 0, 1, '0);
      tick(0, 0, 0, '0, 1, 0);
      tick(0, 0, 0, '0, 1, 1);
      chk("m2_close", 32'(ras_close_valid), 32'd1);
      idle();
      chk("m2_cinv", 32'(ras_close_invalid), 32'd1);
      chk("m2_outst", 32'(outstanding), 32'd0);
      idle();

      // mispredict discards a close still waiting on the gap
      repeat (3) op_acc(0, 0, 1, '0);
      tick(0, 0, 0, '0, 1, 0);
      tick(0, 0, 0, '0, 1, 0);
      tick(0, 0, 0, '0, 1, 1);
      idle();
      chk("m3_cinv", 32'(ras_close_invalid), 32'd1);
      idle();
      chk("m3_no_close", 32'(ras_close_valid), 32'd0);
      repeat (2) idle();

      // unmatched resolution
      tick(0, 0, 0, '0, 1, 0);
      idle();
      chk("err_set", 32'(err), 32'd1);
      repeat (3) idle();
      chk("err_sticky", 32'(err), 32'd1);

      // reset while a ret is in flight
      op_acc(1, 0, 0, 32'h3000);
      op_acc(0, 1, 0, '0);
      rst_tick(0);
      rst_tick(1);
      chk("rst_ret_suppr", 32'(ret_target_valid), 32'd0);
      chk("rst_err_clr", 32'(err), 32'd0);
      idle();
      chk("reinit_cinv", 32'(ras_close_invalid), 32'd1);
      repeat (2) idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
